key_matrix_scanner: RTL
=======================

// Module: key_matrix_scanner
// PURPOSE
//  Input-side counterpart to the LED dot-matrix row/column scan driver.
//  - Drives a passive key matrix one column at a time and samples its rows.
//  - Debounces every key.
//  - Reports each debounced key press as a key code through a valid/ack holding register.
//  - Sits between the board key-matrix pins and user logic, e.g. a pattern selector for the dot-matrix driver.
// PARAMETERS
//  N_COLS         4      columns driven (>=2)
//  N_ROWS         4      rows sensed (>=1)
//  SCAN_DIV       27000  CLK cycles per column dwell (1 ms at 27 MHz)
//  DEBOUNCE_SCANS 3      consecutive frames of changed level needed to flip a key's state (>=1)
// PORTS
//  CLK        in   1               system clock; all logic on its rising edge
//  RESET      in   1               synchronous, active-high reset
//  Col_Drive  out  N_COLS          one-cold column drive; 0 = column driven
//  Row_Sense  in   N_ROWS          raw row inputs; pulled up, 0 = key closed in driven column
//  key_valid  out  1               holding register holds an unconsumed press
//  key_code   out  CODE_W          code of the held press, row*N_COLS+col
//  key_ack    in   1               consumer accept; effective only while key_valid=1
//  key_state  out  N_ROWS*N_COLS   debounced level of every key, bit = code
//  overrun    out  1               sticky: a press was dropped while key_valid=1
// BEHAVIOUR
//  - Reset values (all registered outputs):
//    - Col_Drive = ~1 (column 0 driven).
//    - key_valid=0, key_code=0, key_state=0, overrun=0.
//    - Divider, column index, synchroniser and all debounce counters = 0.
//  - Reset asserted mid-operation aborts any debounce in progress; no event is emitted for it.
//  - Row_Sense passes through a 2-flop synchroniser. Sense = ~synchronised value (1 = pressed).
//  - Divider counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle it equals SCAN_DIV-1.
//  - On tick:
//    - Sense is sampled for the current column col.
//    - col advances, N_COLS-1 wraps to 0.
//    - Col_Drive = ~(1<<col), registered.
//    - A frame is N_COLS ticks; each key is sampled once per frame.
//  - Per-key debounce (key k = row*N_COLS+col), at the tick that samples k:
//    - If sample == key_state[k], cnt[k] is cleared to 0.
//    - Otherwise cnt[k] increments, saturating at DEBOUNCE_SCANS.
//    - When cnt[k] reaches DEBOUNCE_SCANS, the key is eligible to flip.
//  - Flip rules:
//    - Release flip (1->0): key_state[k] clears, cnt[k]=0, no event.
//    - Press flip (0->1): at most one per tick, the lowest row index in the column wins.
//    - Losers keep cnt saturated and flip on a later frame.
//    - The winner sets key_state[k], clears cnt[k] and raises a press event.
//  - Holding register, in the cycle after the sampling tick:
//    - Event with key_valid=0: key_valid<=1, key_code<=k.
//    - Event with key_valid=1 and key_ack=1: accept and load in the same cycle; key_valid stays 1, key_code<=k.
//    - Event with key_valid=1 and key_ack=0: event dropped (key_state still updates), overrun<=1.
//    - key_ack=1 with key_valid=1 and no event: key_valid<=0, overrun<=0.
//    - key_ack while key_valid=0 is ignored.
//    - key_code holds its last value when key_valid=0.
//  - Latency:
//    - Steady press to key_valid: DEBOUNCE_SCANS frames, +2 sync cycles, +1 cycle.
//    - key_state updates on the same tick as the flip, i.e. one cycle before key_valid.
//  - Widths: CODE_W = max(1, clog2(N_ROWS*N_COLS)); column index is clog2(N_COLS) bits; debounce cnt is clog2(DEBOUNCE_SCANS+1) bits.
// STRUCTURE
//  - Shared package key_matrix_pkg:
//    - CODE_W width function.
//    - SCAN_DIV_1MS_27M constant (27000).
//    - Event record typedef {valid, code}.
//  - Sub-module key_debounce: one key's cnt + state, inputs sample_en and sample, outputs state and flip_req.
//    - Instantiated N_ROWS*N_COLS times via generate.
//  - Top level holds: divider, column counter, synchroniser, per-column priority pick, holding register.
// TESTING (sim: N_COLS=4, N_ROWS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3)
//  1. RESET=1 for 2 cycles -> Col_Drive=4'b1110, key_valid=0, key_state=16'h0000, overrun=0.
//  2. No keys -> Col_Drive steps 1110,1101,1011,0111,1110, 4 cycles each; key_valid stays 0.
//  3. Hold row2/col1 closed -> after 3 frames key_state[9]=1, then key_valid=1 with key_code=9.
//     Ack -> key_valid=0. Release -> key_state[9]=0 after 3 frames, no new key_valid.
//  4. Key 5 bounces (closed, open, closed, closed, closed by frame) -> exactly one key_valid, code 5.
//     It asserts after the 3rd consecutive closed frame.
//  5. Press key 0, no ack; then press key 15 -> key_code stays 0, overrun=1, key_state[15]=1.
//     Ack -> key_valid=0, overrun=0.
//  6. Rows 1 and 3 of col 0 closed together -> code 4 reported first; code 12 one frame later.
//     RESET mid-debounce of key 7 -> no event for key 7.

Source files
------------

// File: rtl/key_matrix_pkg.sv
// Shared definitions for the key matrix scanner: code width helper,
// default scan divider and the press event record.
package key_matrix_pkg;

  localparam int unsigned SCAN_DIV_1MS_27M = 27000;
  localparam int unsigned EVT_CODE_MAX_W   = 16;

  function automatic int unsigned code_w(input int unsigned n_keys);
    return (n_keys < 2) ? 1 : int'($clog2(n_keys));
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [EVT_CODE_MAX_W-1:0] code;
  } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One key's debounce counter and debounced state. A press flip additionally
// needs a grant from the column priority pick; release flips are unconditional.
module key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned CNT_W          = $clog2(DEBOUNCE_SCANS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  input  logic grant,
  output logic state,
  output logic flip_req
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    cnt_inc  = (cnt == SAT) ? SAT : cnt + 1'b1;
    flip_req = sample_en && (sample != state) && (cnt_inc == SAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample_en) begin
      if (sample == state) begin
        cnt <= '0;
      end else if (flip_req && (state || grant)) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        // a press that lost arbitration stays saturated and retries next frame
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// Column-scanned key matrix reader: one-cold column drive, synchronised row
// sense, per-key debounce and a valid/ack holding register for key presses.
module key_matrix_scanner
  import key_matrix_pkg::*;
#(
  parameter int unsigned N_COLS         = 4,
  parameter int unsigned N_ROWS         = 4,
  parameter int unsigned SCAN_DIV       = SCAN_DIV_1MS_27M,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  localparam int unsigned N_KEYS        = N_ROWS * N_COLS,
  localparam int unsigned CODE_W        = code_w(N_KEYS)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [N_COLS-1:0] Col_Drive,
  input  logic [N_ROWS-1:0] Row_Sense,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ack,
  output logic [N_KEYS-1:0] key_state,
  output logic              overrun
);

  localparam int unsigned COL_W = $clog2(N_COLS);
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_next;
  logic [N_ROWS-1:0] row_meta;
  logic [N_ROWS-1:0] row_sync;
  logic [N_ROWS-1:0] sense;
  logic [N_KEYS-1:0] flip_req;
  logic [N_KEYS-1:0] grant;
  logic              press_any;
  logic [CODE_W-1:0] press_code;
  key_event_t        evt;

  always_comb begin
    tick     = (div == DIV_W'(SCAN_DIV - 1));
    col_next = (col == COL_W'(N_COLS - 1)) ? '0 : col + 1'b1;
    sense    = ~row_sync;
  end

  // Only the sampled column can request, so the lowest requesting code is
  // also the lowest row in that column.
  always_comb begin
    grant      = '0;
    press_any  = 1'b0;
    press_code = '0;
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      if (!press_any && flip_req[k] && !key_state[k]) begin
        grant[k]   = 1'b1;
        press_any  = 1'b1;
        press_code = CODE_W'(k);
      end
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .CNT_W         (CNT_W)
      ) u_key (
        .clk      (CLK),
        .reset    (RESET),
        .sample_en(tick && (col == COL_W'(c))),
        .sample   (sense[r]),
        .grant    (grant[r*N_COLS+c]),
        .state    (key_state[r*N_COLS+c]),
        .flip_req (flip_req[r*N_COLS+c])
      );
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div       <= '0;
      col       <= '0;
      Col_Drive <= ~(N_COLS'(1));
      row_meta  <= '0;
      row_sync  <= '0;
      evt       <= '0;
    end else begin
      row_meta  <= Row_Sense;
      row_sync  <= row_meta;
      div       <= tick ? '0 : div + 1'b1;
      evt.valid <= press_any;
      evt.code  <= EVT_CODE_MAX_W'(press_code);
      if (tick) begin
        col       <= col_next;
        Col_Drive <= ~(N_COLS'(1) << col_next);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else if (evt.valid) begin
      if (!key_valid || key_ack) begin
        key_valid <= 1'b1;
        key_code  <= CODE_W'(evt.code);
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
